// File: rtl/wb_stage_ext.sv
// Writeback stage: one-entry M->W latch with valid/ready hold on the RF write port,
// writeback-source mux, sub-word load extraction, $0 suppression, misalignment trap,
// forwarding tap and retired-instruction counter.
module wb_stage_ext #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned RADDR_W = 5,
  parameter int unsigned CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_pc4,
  input  logic [DATA_W-1:0]  in_alu,
  input  logic [DATA_W-1:0]  in_mem,
  input  logic [DATA_W-1:0]  in_hilo,
  input  logic [RADDR_W-1:0] in_wreg,
  input  logic               in_regwrite,
  input  logic [1:0]         in_sel,
  input  logic [1:0]         in_ld_size,
  input  logic               in_ld_sign,
  input  logic [1:0]         in_addr_lo,
  input  logic               rf_ready,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]  rf_wdata,
  output logic               fwd_valid,
  output logic [RADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0]  fwd_data,
  output logic               mis_err,
  output logic [CNT_W-1:0]   retire_cnt
);

  localparam logic [1:0] SelAlu  = 2'b00;
  localparam logic [1:0] SelMem  = 2'b01;
  localparam logic [1:0] SelPc8  = 2'b10;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeByte = 2'b10;

  // Stage register
  logic               v_q, v_d;
  logic [DATA_W-1:0]  pc4_q, alu_q, mem_q, hilo_q;
  logic [RADDR_W-1:0] wreg_q;
  logic               regwrite_q;
  logic [1:0]         sel_q, ld_size_q, addr_lo_q;
  logic               ld_sign_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic              accept, complete, misaligned, writes_reg;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DATA_W-1:0] ld_data, wb_data;

  // Handshake: a stalled entry blocks the M stage; flush overrides both accept and complete.
  always_comb begin
    in_ready = !v_q || rf_ready;
    accept   = in_valid && in_ready && !flush;
    complete = v_q && rf_ready && !flush;
    v_d      = v_q;
    if (flush) begin
      v_d = 1'b0;
    end else if (accept) begin
      v_d = 1'b1;
    end else if (complete) begin
      v_d = 1'b0;
    end
    cnt_d = complete ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Little-endian lane extraction, then sign/zero extension; reserved size behaves as word.
  always_comb begin
    ld_byte = mem_q[{addr_lo_q, 3'b000} +: 8];
    ld_half = mem_q[{addr_lo_q[1], 4'b0000} +: 16];
    unique case (ld_size_q)
      SizeByte: ld_data = {{(DATA_W-8){ld_sign_q & ld_byte[7]}}, ld_byte};
      SizeHalf: ld_data = {{(DATA_W-16){ld_sign_q & ld_half[15]}}, ld_half};
      default:  ld_data = mem_q;
    endcase
  end

  // Writeback source mux and write/forward qualification.
  always_comb begin
    unique case (sel_q)
      SelAlu:  wb_data = alu_q;
      SelMem:  wb_data = ld_data;
      SelPc8:  wb_data = pc4_q + DATA_W'(4);
      default: wb_data = hilo_q;
    endcase
    misaligned = (sel_q == SelMem) &&
                 (((ld_size_q == SizeHalf) && addr_lo_q[0]) ||
                  (((ld_size_q == 2'b00) || (ld_size_q == 2'b11)) && (addr_lo_q != 2'b00)));
    writes_reg = regwrite_q && (wreg_q != '0) && !misaligned;
    rf_we      = complete && writes_reg;
    mis_err    = complete && misaligned;
    fwd_valid  = v_q && writes_reg;
    rf_waddr   = wreg_q;
    rf_wdata   = wb_data;
    fwd_addr   = wreg_q;
    fwd_data   = wb_data;
    retire_cnt = cnt_q;
  end

  // Valid bit and retire counter; synchronous reset drops any held entry.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      v_q   <= v_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload fields load only on accept, so a stalled entry stays stable.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc4_q      <= '0;
      alu_q      <= '0;
      mem_q      <= '0;
      hilo_q     <= '0;
      wreg_q     <= '0;
      regwrite_q <= 1'b0;
      sel_q      <= 2'b00;
      ld_size_q  <= 2'b00;
      ld_sign_q  <= 1'b0;
      addr_lo_q  <= 2'b00;
    end else if (accept) begin
      pc4_q      <= in_pc4;
      alu_q      <= in_alu;
      mem_q      <= in_mem;
      hilo_q     <= in_hilo;
      wreg_q     <= in_wreg;
      regwrite_q <= in_regwrite;
      sel_q      <= in_sel;
      ld_size_q  <= in_ld_size;
      ld_sign_q  <= in_ld_sign;
      addr_lo_q  <= in_addr_lo;
    end
  end

endmodule

// File: tb/tb_wb_stage_ext.sv
// Bench for wb_stage_ext: directed vector table, hand-written stall/flush/reset sequences,
// then random traffic against a transaction-level reference model.
module tb_wb_stage_ext;

  localparam int CW = 4;  // narrow counter so wrap-around is reachable

  logic        clk = 1'b0;
  logic        reset_n, flush, in_valid, in_ready;
  logic [31:0] in_pc4, in_alu, in_mem, in_hilo;
  logic [4:0]  in_wreg;
  logic        in_regwrite, in_ld_sign;
  logic [1:0]  in_sel, in_ld_size, in_addr_lo;
  logic        rf_ready, rf_we, fwd_valid, mis_err;
  logic [4:0]  rf_waddr, fwd_addr;
  logic [31:0] rf_wdata, fwd_data;
  logic [CW-1:0] retire_cnt;

  wb_stage_ext #(.DATA_W(32), .RADDR_W(5), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc4(in_pc4), .in_alu(in_alu), .in_mem(in_mem), .in_hilo(in_hilo), .in_wreg(in_wreg),
    .in_regwrite(in_regwrite), .in_sel(in_sel), .in_ld_size(in_ld_size),
    .in_ld_sign(in_ld_sign), .in_addr_lo(in_addr_lo), .rf_ready(rf_ready), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .mis_err(mis_err), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] alu, mem, pc4, hilo;
    logic [4:0]  wreg;
    logic [1:0]  size;
    logic        sign;
    logic [1:0]  a;
    logic        e_we;
    logic        e_mis;
    logic [31:0] e_wdata;
  } vec_t;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] alu, mem, pc4, hilo;
    logic [4:0]  wreg;
    logic        rw;
    logic [1:0]  size;
    logic        sign;
    logic [1:0]  a;
  } ent_t;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic put(input ent_t e);
    in_sel = e.sel; in_alu = e.alu; in_mem = e.mem; in_pc4 = e.pc4; in_hilo = e.hilo;
    in_wreg = e.wreg; in_regwrite = e.rw; in_ld_size = e.size; in_ld_sign = e.sign;
    in_addr_lo = e.a;
  endtask

  // Reference: which bytes a load reads and how it is extended, from the ISA rules.
  function automatic logic [31:0] ref_data(input ent_t e);
    int unsigned v;
    case (e.sel)
      2'd0: return e.alu;
      2'd2: return e.pc4 + 32'd4;
      2'd3: return e.hilo;
      default: begin
        if (e.size == 2'd2) begin
          v = (e.mem / (32'd1 << (8 * e.a))) % 256;
          if (e.sign && v >= 128) v = v + 32'hFFFF_FF00;
          return v;
        end else if (e.size == 2'd1) begin
          v = (e.mem / (32'd1 << (16 * (e.a / 2)))) % 65536;
          if (e.sign && v >= 32768) v = v + 32'hFFFF_0000;
          return v;
        end
        return e.mem;
      end
    endcase
  endfunction

  function automatic logic ref_mis(input ent_t e);
    if (e.sel != 2'd1) return 1'b0;
    if (e.size == 2'd2) return 1'b0;
    if (e.size == 2'd1) return (e.a % 2) != 0;
    return e.a != 0;
  endfunction

  vec_t  vecs[16];
  ent_t  e, m_ent;
  logic  m_v, comp, wr;
  int    exp_cnt;

  initial begin
    vecs[0]  = '{2'd0, 32'h1234_5678, 32'h0, 32'h0, 32'h0, 5'd8, 2'd0, 1'b0, 2'd0,
                 1'b1, 1'b0, 32'h1234_5678};
    vecs[1]  = '{2'd1, 32'h0, 32'h80FF_7F01, 32'h0, 32'h0, 5'd9, 2'd2, 1'b1, 2'd3,
                 1'b1, 1'b0, 32'hFFFF_FF80};
    vecs[2]  = '{2'd1, 32'h0, 32'h80FF_7F01, 32'h0, 32'h0, 5'd9, 2'd2, 1'b0, 2'd3,
                 1'b1, 1'b0, 32'h0000_0080};
    vecs[3]  = '{2'd1, 32'h0, 32'h80FF_7F01, 32'h0, 32'h0, 5'd9, 2'd2, 1'b1, 2'd1,
                 1'b1, 1'b0, 32'h0000_007F};
    vecs[4]  = '{2'd2, 32'h0, 32'h0, 32'h0000_3004, 32'h0, 5'd31, 2'd0, 1'b0, 2'd0,
                 1'b1, 1'b0, 32'h0000_3008};
    vecs[5]  = '{2'd2, 32'h0, 32'h0, 32'hFFFF_FFFC, 32'h0, 5'd31, 2'd0, 1'b0, 2'd0,
                 1'b1, 1'b0, 32'h0000_0000};
    vecs[6]  = '{2'd0, 32'hCAFE_F00D, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0, 2'd0,
                 1'b0, 1'b0, 32'hCAFE_F00D};
    vecs[7]  = '{2'd1, 32'h0, 32'h80FF_7F01, 32'h0, 32'h0, 5'd4, 2'd1, 1'b1, 2'd1,
                 1'b0, 1'b1, 32'h0000_7F01};
    vecs[8]  = '{2'd1, 32'h0, 32'h80FF_7F01, 32'h0, 32'h0, 5'd4, 2'd1, 1'b1, 2'd2,
                 1'b1, 1'b0, 32'hFFFF_80FF};
    vecs[9]  = '{2'd1, 32'h0, 32'h80FF_7F01, 32'h0, 32'h0, 5'd4, 2'd1, 1'b0, 2'd2,
                 1'b1, 1'b0, 32'h0000_80FF};
    vecs[10] = '{2'd1, 32'h0, 32'h80FF_7F01, 32'h0, 32'h0, 5'd6, 2'd0, 1'b0, 2'd0,
                 1'b1, 1'b0, 32'h80FF_7F01};
    vecs[11] = '{2'd1, 32'h0, 32'h80FF_7F01, 32'h0, 32'h0, 5'd6, 2'd0, 1'b0, 2'd2,
                 1'b0, 1'b1, 32'h80FF_7F01};
    vecs[12] = '{2'd3, 32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 5'd2, 2'd0, 1'b0, 2'd0,
                 1'b1, 1'b0, 32'hDEAD_BEEF};
    vecs[13] = '{2'd1, 32'h0, 32'h80FF_7F01, 32'h0, 32'h0, 5'd7, 2'd3, 1'b0, 2'd1,
                 1'b0, 1'b1, 32'h80FF_7F01};
    vecs[14] = '{2'd1, 32'h0, 32'h80FF_7F01, 32'h0, 32'h0, 5'd7, 2'd3, 1'b0, 2'd0,
                 1'b1, 1'b0, 32'h80FF_7F01};
    vecs[15] = '{2'd1, 32'h0, 32'h80FF_7F01, 32'h0, 32'h0, 5'd7, 2'd2, 1'b0, 2'd0,
                 1'b1, 1'b0, 32'h0000_0001};

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; rf_ready = 1'b1;
    e = '{2'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 2'd0, 1'b0, 2'd0};
    put(e);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rst_rf_we", {31'b0, rf_we}, 32'd0);
    chk("rst_fwd_valid", {31'b0, fwd_valid}, 32'd0);
    chk("rst_mis_err", {31'b0, mis_err}, 32'd0);
    chk("rst_rf_waddr", {27'b0, rf_waddr}, 32'd0);
    chk("rst_rf_wdata", rf_wdata, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_cnt", {28'b0, retire_cnt}, 32'd0);

    // Directed vectors: accept one cycle, complete the next.
    exp_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      e = '{vecs[i].sel, vecs[i].alu, vecs[i].mem, vecs[i].pc4, vecs[i].hilo, vecs[i].wreg,
            1'b1, vecs[i].size, vecs[i].sign, vecs[i].a};
      put(e);
      in_valid = 1'b1; rf_ready = 1'b1;
      #1 chk($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk($sformatf("v%0d_rf_we", i), {31'b0, rf_we}, {31'b0, vecs[i].e_we});
      chk($sformatf("v%0d_mis_err", i), {31'b0, mis_err}, {31'b0, vecs[i].e_mis});
      chk($sformatf("v%0d_fwd_valid", i), {31'b0, fwd_valid}, {31'b0, vecs[i].e_we});
      chk($sformatf("v%0d_rf_waddr", i), {27'b0, rf_waddr}, {27'b0, vecs[i].wreg});
      chk($sformatf("v%0d_rf_wdata", i), rf_wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d_fwd_data", i), fwd_data, vecs[i].e_wdata);
      chk($sformatf("v%0d_cnt", i), {28'b0, retire_cnt}, exp_cnt % 16);
      exp_cnt++;
    end
    @(negedge clk);
    #1 chk("cnt_wrap", {28'b0, retire_cnt}, 32'd0);
    exp_cnt = 0;

    // Stall: held entry stays visible, later offers are refused.
    e = '{2'd0, 32'h1111_2222, 32'h0, 32'h0, 32'h0, 5'd5, 1'b1, 2'd0, 1'b0, 2'd0};
    put(e); in_valid = 1'b1; rf_ready = 1'b1;
    @(negedge clk);
    e.alu = 32'h9999_AAAA; e.wreg = 5'd6;
    put(e); rf_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
      chk("stall_rf_we", {31'b0, rf_we}, 32'd0);
      chk("stall_fwd_valid", {31'b0, fwd_valid}, 32'd1);
      chk("stall_fwd_data", fwd_data, 32'h1111_2222);
      chk("stall_waddr", {27'b0, rf_waddr}, 32'd5);
      chk("stall_cnt", {28'b0, retire_cnt}, 32'd0);
      @(negedge clk);
    end
    rf_ready = 1'b1; in_valid = 1'b0;
    #1;
    chk("unstall_rf_we", {31'b0, rf_we}, 32'd1);
    chk("unstall_wdata", rf_wdata, 32'h1111_2222);
    @(negedge clk);
    #1;
    chk("unstall_cnt", {28'b0, retire_cnt}, 32'd1);
    chk("unstall_empty", {31'b0, fwd_valid}, 32'd0);

    // Flush with write port ready: held entry must not write or retire; offer dropped.
    @(negedge clk);
    e.alu = 32'h3333_4444; e.wreg = 5'd10;
    put(e); in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b1; e.wreg = 5'd11; put(e);
    #1 chk("flush_rf_we", {31'b0, rf_we}, 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; rf_ready = 1'b0;
    #1;
    chk("flush_fwd_valid", {31'b0, fwd_valid}, 32'd0);
    chk("flush_in_ready", {31'b0, in_ready}, 32'd1);
    chk("flush_cnt", {28'b0, retire_cnt}, 32'd1);

    // Reset while stalled drops the entry.
    in_valid = 1'b1; rf_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; rf_ready = 1'b0;
    #1 chk("pre_rst_fwd", {31'b0, fwd_valid}, 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst_fwd_valid", {31'b0, fwd_valid}, 32'd0);
    chk("midrst_waddr", {27'b0, rf_waddr}, 32'd0);
    chk("midrst_wdata", rf_wdata, 32'd0);
    chk("midrst_cnt", {28'b0, retire_cnt}, 32'd0);
    rf_ready = 1'b1;
    #1 chk("midrst_rf_we", {31'b0, rf_we}, 32'd0);

    // Random traffic against the transaction model.
    m_v = 1'b0; exp_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      e.sel  = 2'($urandom_range(0, 3));
      e.alu  = $urandom; e.mem = $urandom; e.hilo = $urandom;
      e.pc4  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      e.wreg = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      e.rw   = ($urandom_range(0, 5) != 0);
      e.size = 2'($urandom); e.sign = 1'($urandom); e.a = 2'($urandom);
      put(e);
      in_valid = ($urandom_range(0, 3) != 0);
      rf_ready = ($urandom_range(0, 9) < 7);
      flush    = ($urandom_range(0, 19) == 0);
      #1;
      comp = m_v && rf_ready && !flush;
      wr   = m_ent.rw && (m_ent.wreg != 0) && !ref_mis(m_ent);
      chk("r_in_ready", {31'b0, in_ready}, {31'b0, !m_v || rf_ready});
      chk("r_rf_we", {31'b0, rf_we}, {31'b0, comp && wr});
      chk("r_mis_err", {31'b0, mis_err}, {31'b0, comp && ref_mis(m_ent)});
      chk("r_fwd_valid", {31'b0, fwd_valid}, {31'b0, m_v && wr});
      chk("r_cnt", {28'b0, retire_cnt}, exp_cnt % 16);
      if (m_v) begin
        chk("r_waddr", {27'b0, rf_waddr}, {27'b0, m_ent.wreg});
        chk("r_wdata", rf_wdata, ref_data(m_ent));
        chk("r_fwd_addr", {27'b0, fwd_addr}, {27'b0, m_ent.wreg});
        chk("r_fwd_data", fwd_data, ref_data(m_ent));
      end
      @(posedge clk);
      if (flush) begin
        m_v = 1'b0;
      end else begin
        if (comp) begin
          exp_cnt++;
          m_v = 1'b0;
        end
        if (in_valid && !m_v) begin
          m_v = 1'b1;
          m_ent = e;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
